// File: rtl/k423_pcu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : k423_pcu_pkg
// Brief    : Shared types and control encodings for the k423 pipeline control unit
// Revision : 1.0 - initial release
// ============================================================================
package k423_pcu_pkg;

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        F_DRAIN   = 2'd1,
        F_INV     = 2'd2,
        F_RESTART = 2'd3
    } pcu_state_e;

    typedef struct packed {
        logic stall_pc;
        logic stall_if_id;
        logic stall_id_ex;
        logic stall_ex_mem;
        logic clear_if_id;
        logic clear_id_ex;
        logic clear_ex_mem;
        logic clear_mem_wb;
    } pcu_ctrl_t;

    localparam pcu_ctrl_t c_ctrl_none    = 8'b0000_0000;
    localparam pcu_ctrl_t c_ctrl_trap    = 8'b0000_1111;
    localparam pcu_ctrl_t c_ctrl_lsu     = 8'b1111_0001;
    localparam pcu_ctrl_t c_ctrl_mispred = 8'b0000_1100;
    localparam pcu_ctrl_t c_ctrl_mdu     = 8'b1110_0010;
    // Fence holds the PC and lets the fence itself leave ID while younger fetches die
    localparam pcu_ctrl_t c_ctrl_fence   = 8'b1000_1000;
    localparam pcu_ctrl_t c_ctrl_lduse   = 8'b1100_0100;

endpackage
`default_nettype wire

// File: rtl/k423_pcu_fence_fsm.sv
`default_nettype none
// ============================================================================
// Module   : k423_pcu_fence_fsm
// Brief    : fence.i drain/invalidate/restart sequencer with fence PC capture
// Revision : 1.0 - initial release
// ============================================================================
module k423_pcu_fence_fsm
    import k423_pcu_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              trap_i,
    input  logic              drained_i,
    input  logic              inv_done_i,
    input  logic [ADDR_W-1:0] fence_pc_i,
    output pcu_state_e        state_o,
    output logic              inv_pulse_o,
    output logic [ADDR_W-1:0] restart_pc_o
);

    localparam logic [1:0] c_st_run     = 2'd0;
    localparam logic [1:0] c_st_drain   = 2'd1;
    localparam logic [1:0] c_st_inv     = 2'd2;
    localparam logic [1:0] c_st_restart = 2'd3;

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [ADDR_W-1:0] r_fence_pc;
    logic              r_inv_sent;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_run: begin
                if (start_i) w_state_nxt = c_st_drain;
            end
            c_st_drain: begin
                if (trap_i)         w_state_nxt = c_st_run;
                else if (drained_i) w_state_nxt = c_st_inv;
            end
            c_st_inv: begin
                if (trap_i)          w_state_nxt = c_st_run;
                else if (inv_done_i) w_state_nxt = c_st_restart;
            end
            c_st_restart: w_state_nxt = c_st_run;
            default:      w_state_nxt = c_st_run;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= c_st_run;
            r_fence_pc <= '0;
            r_inv_sent <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            // Marks that the invalidate already went out for this F_INV visit
            r_inv_sent <= (r_state == c_st_inv);
            if ((r_state == c_st_run) && start_i) r_fence_pc <= fence_pc_i;
        end
    end

    assign state_o      = pcu_state_e'(r_state);
    assign inv_pulse_o  = (r_state == c_st_inv) && !r_inv_sent && !trap_i;
    assign restart_pc_o = r_fence_pc + ADDR_W'(4);

endmodule
`default_nettype wire

// File: rtl/k423_pcu.sv
`default_nettype none
// ============================================================================
// Module   : k423_pcu
// Brief    : k423 pipeline control unit - hazard/redirect/trap priority and stall counter
// Revision : 1.0 - initial release
// ============================================================================
module k423_pcu
    import k423_pcu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              id_vld_i,
    input  logic [ADDR_W-1:0] id_pc_i,
    input  logic              id_ld_use_hzd_i,
    input  logic              id_fence_i,
    input  logic              ex_vld_i,
    input  logic              mem_vld_i,
    input  logic              wb_vld_i,
    input  logic              ex_bpu_mispred_i,
    input  logic [ADDR_W-1:0] ex_redirect_pc_i,
    input  logic              ex_mdu_busy_i,
    input  logic              mem_lsu_stall_i,
    input  logic              mem_trap_i,
    input  logic [ADDR_W-1:0] mem_trap_pc_i,
    input  logic              icache_inv_done_i,
    output logic              pcu_stall_pc_o,
    output logic              pcu_stall_if_id_o,
    output logic              pcu_stall_id_ex_o,
    output logic              pcu_stall_ex_mem_o,
    output logic              pcu_clear_if_id_o,
    output logic              pcu_clear_id_ex_o,
    output logic              pcu_clear_ex_mem_o,
    output logic              pcu_clear_mem_wb_o,
    output logic              pcu_redirect_vld_o,
    output logic [ADDR_W-1:0] pcu_redirect_pc_o,
    output logic              pcu_icache_inv_o,
    output logic [CNT_W-1:0]  pcu_stall_cnt_o
);

    pcu_state_e        w_state;
    logic              w_inv_pulse;
    logic [ADDR_W-1:0] w_restart_pc;
    logic              w_fence_start;
    pcu_ctrl_t         w_ctrl;
    pcu_ctrl_t         w_ctrl_out;
    logic              w_redir_vld;
    logic [ADDR_W-1:0] w_redir_pc;
    logic [CNT_W-1:0]  r_stall_cnt;

    k423_pcu_fence_fsm #(
        .ADDR_W (ADDR_W)
    ) u_fence_fsm (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .start_i      (w_fence_start),
        .trap_i       (mem_trap_i),
        .drained_i    (!ex_vld_i && !mem_vld_i && !wb_vld_i),
        .inv_done_i   (icache_inv_done_i),
        .fence_pc_i   (id_pc_i),
        .state_o      (w_state),
        .inv_pulse_o  (w_inv_pulse),
        .restart_pc_o (w_restart_pc)
    );

    always_comb begin
        w_ctrl        = c_ctrl_none;
        w_redir_vld   = 1'b0;
        w_redir_pc    = '0;
        w_fence_start = 1'b0;
        if (mem_trap_i) begin
            w_ctrl      = c_ctrl_trap;
            w_redir_vld = 1'b1;
            w_redir_pc  = mem_trap_pc_i;
        end else if (mem_lsu_stall_i && (w_state == RUN || w_state == F_DRAIN)) begin
            w_ctrl = c_ctrl_lsu;
        end else begin
            case (w_state)
                RUN: begin
                    if (ex_bpu_mispred_i) begin
                        w_ctrl      = c_ctrl_mispred;
                        w_redir_vld = 1'b1;
                        w_redir_pc  = ex_redirect_pc_i;
                    end else if (ex_mdu_busy_i) begin
                        w_ctrl = c_ctrl_mdu;
                    end else if (id_fence_i && id_vld_i) begin
                        w_ctrl        = c_ctrl_fence;
                        w_fence_start = 1'b1;
                    end else if (id_ld_use_hzd_i) begin
                        w_ctrl = c_ctrl_lduse;
                    end
                end
                F_DRAIN, F_INV: w_ctrl = c_ctrl_fence;
                F_RESTART: begin
                    w_redir_vld = 1'b1;
                    w_redir_pc  = w_restart_pc;
                end
                default: w_ctrl = c_ctrl_none;
            endcase
        end
    end

    // Outputs are forced quiet while reset is held so no pulse leaks out mid-fence
    assign w_ctrl_out         = rst_i ? c_ctrl_none : w_ctrl;
    assign pcu_stall_pc_o     = w_ctrl_out.stall_pc;
    assign pcu_stall_if_id_o  = w_ctrl_out.stall_if_id;
    assign pcu_stall_id_ex_o  = w_ctrl_out.stall_id_ex;
    assign pcu_stall_ex_mem_o = w_ctrl_out.stall_ex_mem;
    assign pcu_clear_if_id_o  = w_ctrl_out.clear_if_id;
    assign pcu_clear_id_ex_o  = w_ctrl_out.clear_id_ex;
    assign pcu_clear_ex_mem_o = w_ctrl_out.clear_ex_mem;
    assign pcu_clear_mem_wb_o = w_ctrl_out.clear_mem_wb;
    assign pcu_redirect_vld_o = w_redir_vld && !rst_i;
    assign pcu_redirect_pc_o  = rst_i ? '0 : w_redir_pc;
    assign pcu_icache_inv_o   = w_inv_pulse && !rst_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_stall_cnt <= '0;
        end else if (pcu_stall_pc_o && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    assign pcu_stall_cnt_o = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_k423_pcu.sv
`default_nettype none
// ============================================================================
// Module   : tb_k423_pcu
// Brief    : Vector-table and scoreboard bench for k423_pcu
// Revision : 1.0 - initial release
// ============================================================================
module tb_k423_pcu;

    localparam int ADDR_W = 32;
    localparam int CNT_W  = 4;

    typedef struct packed {
        logic        rst;
        logic        id_vld;
        logic [31:0] id_pc;
        logic        ld_use;
        logic        fence;
        logic        ex_vld;
        logic        mem_vld;
        logic        wb_vld;
        logic        mispred;
        logic [31:0] ex_pc;
        logic        mdu;
        logic        lsu;
        logic        trap;
        logic [31:0] trap_pc;
        logic        inv_done;
    } stim_t;

    // ctl = {stall pc,if_id,id_ex,ex_mem, clear if_id,id_ex,ex_mem,mem_wb}
    typedef struct packed {
        logic [7:0]  ctl;
        logic        rv;
        logic [31:0] rpc;
        logic        inv;
    } resp_t;

    typedef struct {
        string name;
        stim_t s;
        resp_t r;
    } vec_t;

    typedef struct {
        string            name;
        resp_t            r;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    localparam logic [7:0] c_none  = 8'b0000_0000;
    localparam logic [7:0] c_trap  = 8'b0000_1111;
    localparam logic [7:0] c_lsu   = 8'b1111_0001;
    localparam logic [7:0] c_misp  = 8'b0000_1100;
    localparam logic [7:0] c_mdu   = 8'b1110_0010;
    localparam logic [7:0] c_fence = 8'b1000_1000;
    localparam logic [7:0] c_lduse = 8'b1100_0100;

    logic clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    logic              rst_i;
    logic              id_vld_i, id_ld_use_hzd_i, id_fence_i;
    logic [ADDR_W-1:0] id_pc_i, ex_redirect_pc_i, mem_trap_pc_i;
    logic              ex_vld_i, mem_vld_i, wb_vld_i;
    logic              ex_bpu_mispred_i, ex_mdu_busy_i, mem_lsu_stall_i, mem_trap_i;
    logic              icache_inv_done_i;
    logic              pcu_stall_pc_o, pcu_stall_if_id_o, pcu_stall_id_ex_o, pcu_stall_ex_mem_o;
    logic              pcu_clear_if_id_o, pcu_clear_id_ex_o, pcu_clear_ex_mem_o, pcu_clear_mem_wb_o;
    logic              pcu_redirect_vld_o, pcu_icache_inv_o;
    logic [ADDR_W-1:0] pcu_redirect_pc_o;
    logic [CNT_W-1:0]  pcu_stall_cnt_o;

    k423_pcu #(
        .ADDR_W (ADDR_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk_i              (clk_i),
        .rst_i              (rst_i),
        .id_vld_i           (id_vld_i),
        .id_pc_i            (id_pc_i),
        .id_ld_use_hzd_i    (id_ld_use_hzd_i),
        .id_fence_i         (id_fence_i),
        .ex_vld_i           (ex_vld_i),
        .mem_vld_i          (mem_vld_i),
        .wb_vld_i           (wb_vld_i),
        .ex_bpu_mispred_i   (ex_bpu_mispred_i),
        .ex_redirect_pc_i   (ex_redirect_pc_i),
        .ex_mdu_busy_i      (ex_mdu_busy_i),
        .mem_lsu_stall_i    (mem_lsu_stall_i),
        .mem_trap_i         (mem_trap_i),
        .mem_trap_pc_i      (mem_trap_pc_i),
        .icache_inv_done_i  (icache_inv_done_i),
        .pcu_stall_pc_o     (pcu_stall_pc_o),
        .pcu_stall_if_id_o  (pcu_stall_if_id_o),
        .pcu_stall_id_ex_o  (pcu_stall_id_ex_o),
        .pcu_stall_ex_mem_o (pcu_stall_ex_mem_o),
        .pcu_clear_if_id_o  (pcu_clear_if_id_o),
        .pcu_clear_id_ex_o  (pcu_clear_id_ex_o),
        .pcu_clear_ex_mem_o (pcu_clear_ex_mem_o),
        .pcu_clear_mem_wb_o (pcu_clear_mem_wb_o),
        .pcu_redirect_vld_o (pcu_redirect_vld_o),
        .pcu_redirect_pc_o  (pcu_redirect_pc_o),
        .pcu_icache_inv_o   (pcu_icache_inv_o),
        .pcu_stall_cnt_o    (pcu_stall_cnt_o)
    );

    int               n_chk  = 0;
    int               n_fail = 0;
    exp_t             sb_q[$];
    vec_t             tbl[$];
    logic [CNT_W-1:0] model_cnt;

    function automatic resp_t mk_r(logic [7:0] c, logic v, logic [31:0] p, logic i);
        resp_t r;
        r.ctl = c;
        r.rv  = v;
        r.rpc = p;
        r.inv = i;
        return r;
    endfunction

    task automatic add(input string name, input stim_t s, input resp_t r);
        vec_t v;
        v.name = name;
        v.s    = s;
        v.r    = r;
        tbl.push_back(v);
    endtask

    // Drive one cycle of stimulus and queue what the DUT must show during it
    task automatic apply(input string name, input stim_t s, input resp_t r);
        exp_t e;
        @(posedge clk_i);
        #1;
        rst_i             = s.rst;
        id_vld_i          = s.id_vld;
        id_pc_i           = s.id_pc;
        id_ld_use_hzd_i   = s.ld_use;
        id_fence_i        = s.fence;
        ex_vld_i          = s.ex_vld;
        mem_vld_i         = s.mem_vld;
        wb_vld_i          = s.wb_vld;
        ex_bpu_mispred_i  = s.mispred;
        ex_redirect_pc_i  = s.ex_pc;
        ex_mdu_busy_i     = s.mdu;
        mem_lsu_stall_i   = s.lsu;
        mem_trap_i        = s.trap;
        mem_trap_pc_i     = s.trap_pc;
        icache_inv_done_i = s.inv_done;
        e.name = name;
        e.r    = r;
        e.cnt  = model_cnt;
        sb_q.push_back(e);
        if (s.rst) model_cnt = '0;
        else if (r.ctl[7] && model_cnt != '1) model_cnt = model_cnt + 1'b1;
    endtask

    exp_t        cur;
    logic [7:0]  act_ctl;
    always @(negedge clk_i) begin
        if (sb_q.size() > 0) begin
            cur = sb_q.pop_front();
            act_ctl = {pcu_stall_pc_o, pcu_stall_if_id_o, pcu_stall_id_ex_o, pcu_stall_ex_mem_o,
                       pcu_clear_if_id_o, pcu_clear_id_ex_o, pcu_clear_ex_mem_o, pcu_clear_mem_wb_o};
            n_chk++;
            if (act_ctl !== cur.r.ctl || pcu_redirect_vld_o !== cur.r.rv || pcu_icache_inv_o !== cur.r.inv
                || (cur.r.rv && pcu_redirect_pc_o !== cur.r.rpc)) begin
                n_fail++;
                $display("FAIL %s: got ctl=%b rv=%b rpc=%h inv=%b, expected ctl=%b rv=%b rpc=%h inv=%b",
                         cur.name, act_ctl, pcu_redirect_vld_o, pcu_redirect_pc_o, pcu_icache_inv_o,
                         cur.r.ctl, cur.r.rv, cur.r.rpc, cur.r.inv);
            end
            n_chk++;
            if (pcu_stall_cnt_o !== cur.cnt) begin
                n_fail++;
                $display("FAIL %s stall_cnt: got %0d, expected %0d", cur.name, pcu_stall_cnt_o, cur.cnt);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        stim_t z;
        z = '0;
        {rst_i, id_vld_i, id_ld_use_hzd_i, id_fence_i, ex_vld_i, mem_vld_i, wb_vld_i} = '0;
        {ex_bpu_mispred_i, ex_mdu_busy_i, mem_lsu_stall_i, mem_trap_i, icache_inv_done_i} = '0;
        id_pc_i = '0; ex_redirect_pc_i = '0; mem_trap_pc_i = '0;
        rst_i = 1'b1;
        repeat (3) @(posedge clk_i);
        model_cnt = '0;

        add("reset",         '{default:'0, rst:1'b1}, mk_r(c_none, 0, 0, 0));
        add("idle",          z, mk_r(c_none, 0, 0, 0));
        add("ld_use",        '{default:'0, id_vld:1'b1, ld_use:1'b1}, mk_r(c_lduse, 0, 0, 0));
        add("idle_cnt1",     z, mk_r(c_none, 0, 0, 0));
        add("misp_lduse",    '{default:'0, id_vld:1'b1, ld_use:1'b1, mispred:1'b1, ex_pc:32'h0000_0100},
                             mk_r(c_misp, 1, 32'h0000_0100, 0));
        add("trap_lsu",      '{default:'0, trap:1'b1, lsu:1'b1, trap_pc:32'h8000_0000},
                             mk_r(c_trap, 1, 32'h8000_0000, 0));
        add("lsu_over_misp", '{default:'0, lsu:1'b1, mispred:1'b1, mdu:1'b1, ex_pc:32'h40}, mk_r(c_lsu, 0, 0, 0));
        add("mdu_over_fence",'{default:'0, mdu:1'b1, fence:1'b1, id_vld:1'b1, id_pc:32'h80}, mk_r(c_mdu, 0, 0, 0));
        add("fence_invalid", '{default:'0, fence:1'b1, ld_use:1'b1}, mk_r(c_lduse, 0, 0, 0));
        // fence.i at 0x200: 3 drain cycles, inv pulse, done 2 cycles later, restart
        add("fence_run",     '{default:'0, id_vld:1'b1, fence:1'b1, ld_use:1'b1, id_pc:32'h200,
                               ex_vld:1'b1, mem_vld:1'b1, wb_vld:1'b1}, mk_r(c_fence, 0, 0, 0));
        add("drain1",        '{default:'0, id_vld:1'b1, fence:1'b1, id_pc:32'h999,
                               ex_vld:1'b1, mem_vld:1'b1, wb_vld:1'b1}, mk_r(c_fence, 0, 0, 0));
        add("drain2_misp",   '{default:'0, mispred:1'b1, ex_pc:32'h300, mdu:1'b1,
                               ex_vld:1'b1, mem_vld:1'b1, wb_vld:1'b1}, mk_r(c_fence, 0, 0, 0));
        add("drain3",        z, mk_r(c_fence, 0, 0, 0));
        add("inv_first",     z, mk_r(c_fence, 0, 0, 1));
        add("inv_hold",      z, mk_r(c_fence, 0, 0, 0));
        add("inv_done",      '{default:'0, inv_done:1'b1}, mk_r(c_fence, 0, 0, 0));
        add("restart",       z, mk_r(c_none, 1, 32'h0000_0204, 0));
        add("back_run",      z, mk_r(c_none, 0, 0, 0));
        // Wrap-around target, done arriving on the F_INV entry cycle
        add("wrap_run",      '{default:'0, id_vld:1'b1, fence:1'b1, id_pc:32'hFFFF_FFFC}, mk_r(c_fence, 0, 0, 0));
        add("wrap_drain",    z, mk_r(c_fence, 0, 0, 0));
        add("wrap_inv_done", '{default:'0, inv_done:1'b1}, mk_r(c_fence, 0, 0, 1));
        add("wrap_restart",  z, mk_r(c_none, 1, 32'h0000_0000, 0));
        add("wrap_run2",     z, mk_r(c_none, 0, 0, 0));
        // lsu stall then trap while draining
        add("td_run",        '{default:'0, id_vld:1'b1, fence:1'b1, id_pc:32'h400,
                               ex_vld:1'b1, mem_vld:1'b1, wb_vld:1'b1}, mk_r(c_fence, 0, 0, 0));
        add("td_lsu",        '{default:'0, lsu:1'b1, mem_vld:1'b1}, mk_r(c_lsu, 0, 0, 0));
        add("td_trap",       '{default:'0, trap:1'b1, trap_pc:32'h0000_0080, mem_vld:1'b1},
                             mk_r(c_trap, 1, 32'h0000_0080, 0));
        add("td_run_after",  z, mk_r(c_none, 0, 0, 0));

        for (int i = 0; i < tbl.size(); i++) apply(tbl[i].name, tbl[i].s, tbl[i].r);

        for (int i = 0; i < 20; i++) apply("mdu_sat", '{default:'0, mdu:1'b1}, mk_r(c_mdu, 0, 0, 0));
        apply("sat_idle", z, mk_r(c_none, 0, 0, 0));

        // Reset landing in F_INV must kill the inv pulse and the fence sequence
        apply("ri_run",   '{default:'0, id_vld:1'b1, fence:1'b1, id_pc:32'h500}, mk_r(c_fence, 0, 0, 0));
        apply("ri_drain", z, mk_r(c_none | c_fence, 0, 0, 0));
        apply("ri_rst",   '{default:'0, rst:1'b1}, mk_r(c_none, 0, 0, 0));
        apply("ri_after", z, mk_r(c_none, 0, 0, 0));
        apply("ri_done",  '{default:'0, inv_done:1'b1}, mk_r(c_none, 0, 0, 0));
        apply("ri_idle",  z, mk_r(c_none, 0, 0, 0));

        for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(negedge clk_i);
        #1;
        if (sb_q.size() != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
